// File: rtl/vproc_opfetch_seq.sv
// vproc_opfetch_seq: multi-operand vector register fetch sequencer.
// Latches one instruction's operand descriptors and emits one beat per
// register-group slice with per-operand VRF address, fetch, shift and
// hazard-release controls. A request can be taken on the last beat's
// handshake, so consecutive instructions issue with no bubble.
// Optional build macro VPROC_OPFETCH_STALL_CNT_EN adds a saturating
// 32-bit stall counter output (stall_cnt_o).
module vproc_opfetch_seq #(
   parameter int N_OPS         = 2,
   parameter int EMUL_MAX_LOG2 = 3,
   parameter int ID_W          = 3
) (
   input  logic                 clk_i,
   input  logic                 sync_rst_i,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic [ID_W-1:0]      req_id_i,
   input  logic [1:0]           req_emul_i,
   input  logic [N_OPS-1:0]     req_vreg_i,
   input  logic [5*N_OPS-1:0]   req_base_i,
   input  logic [N_OPS-1:0]     req_narrow_i,
   output logic                 beat_valid_o,
   input  logic                 beat_ready_i,
   output logic [ID_W-1:0]      beat_id_o,
   output logic [5*N_OPS-1:0]   beat_addr_o,
   output logic [N_OPS-1:0]     beat_fetch_o,
   output logic [N_OPS-1:0]     beat_shift_o,
   output logic [N_OPS-1:0]     beat_clear_hazard_o,
   output logic                 beat_first_o,
   output logic                 beat_last_o,
`ifdef VPROC_OPFETCH_STALL_CNT_EN
   output logic [31:0]          stall_cnt_o,
`endif
   output logic                 busy_o
);

   localparam int CW = (EMUL_MAX_LOG2 < 1) ? 1 : EMUL_MAX_LOG2;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   state_e               state_r, state_nxt;
   logic [CW-1:0]        cnt_r, cnt_nxt;
   logic [CW-1:0]        last_idx_r;
   logic [ID_W-1:0]      id_r;
   logic [N_OPS-1:0]     vreg_r;
   logic [N_OPS-1:0]     narrow_r;
   logic [5*N_OPS-1:0]   base_r;
   logic                 load_s;
   logic                 beat_hs_s;

   // descriptors seen by the next beat: fresh request when loading, else latched
   logic [CW-1:0]        last_idx_s;
   logic [ID_W-1:0]      id_s;
   logic [N_OPS-1:0]     vreg_s;
   logic [N_OPS-1:0]     narrow_s;
   logic [5*N_OPS-1:0]   base_s;

   // next-cycle values of the registered beat outputs
   logic                 valid_nxt;
   logic [ID_W-1:0]      id_nxt;
   logic [5*N_OPS-1:0]   addr_nxt;
   logic [N_OPS-1:0]     fetch_nxt;
   logic [N_OPS-1:0]     shift_nxt;
   logic [N_OPS-1:0]     clear_nxt;
   logic                 first_nxt;
   logic                 last_nxt;
   logic [CW-1:0]        off_s;

   // Index of the final beat: 2^min(emul, EMUL_MAX_LOG2) - 1.
   function automatic logic [CW-1:0] last_idx_of(input logic [1:0] emul);
      int e;
      e = int'(emul);
      e = (e > EMUL_MAX_LOG2) ? EMUL_MAX_LOG2 : e;
      return CW'((32'd1 << e) - 32'd1);
   endfunction

   assign beat_hs_s   = beat_valid_o & beat_ready_i;
   assign req_ready_o = (state_r == ST_IDLE) | (beat_hs_s & beat_last_o);
   assign busy_o      = (state_r == ST_RUN);

   assign last_idx_s = load_s ? last_idx_of(req_emul_i) : last_idx_r;
   assign id_s       = load_s ? req_id_i     : id_r;
   assign vreg_s     = load_s ? req_vreg_i   : vreg_r;
   assign narrow_s   = load_s ? req_narrow_i : narrow_r;
   assign base_s     = load_s ? req_base_i   : base_r;

   // Next-state and beat-counter logic, including back-to-back restart on last beat.
   always_comb begin
      state_nxt = state_r;
      cnt_nxt   = cnt_r;
      load_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (req_valid_i) begin
               state_nxt = ST_RUN;
               cnt_nxt   = {CW{1'b0}};
               load_s    = 1'b1;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (beat_hs_s) begin
               if (beat_last_o) begin
                  cnt_nxt = {CW{1'b0}};
                  if (req_valid_i) begin
                     state_nxt = ST_RUN;
                     load_s    = 1'b1;
                  end else begin
                     state_nxt = ST_IDLE;
                  end
               end else begin
                  cnt_nxt = cnt_r + CW'(1'b1);
               end
            end else begin
               cnt_nxt = cnt_r;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = {CW{1'b0}};
         end
      endcase
   end

   // Beat payload for the next cycle; a stall recomputes identical values.
   always_comb begin
      valid_nxt = 1'b0;
      id_nxt    = {ID_W{1'b0}};
      addr_nxt  = {(5*N_OPS){1'b0}};
      fetch_nxt = {N_OPS{1'b0}};
      shift_nxt = {N_OPS{1'b0}};
      clear_nxt = {N_OPS{1'b0}};
      first_nxt = 1'b0;
      last_nxt  = 1'b0;
      off_s     = {CW{1'b0}};
      if (state_nxt == ST_RUN) begin
         valid_nxt = 1'b1;
         id_nxt    = id_s;
         first_nxt = (cnt_nxt == {CW{1'b0}});
         last_nxt  = (cnt_nxt == last_idx_s);
         for (int i = 0; i < N_OPS; i++) begin
            // a narrow operand advances one register every two beats
            off_s = narrow_s[i] ? (cnt_nxt >> 1'b1) : cnt_nxt;
            addr_nxt[5*i +: 5] = base_s[5*i +: 5] | 5'(off_s);
            fetch_nxt[i] = vreg_s[i] & (narrow_s[i] ? ~cnt_nxt[0] : 1'b1);
            shift_nxt[i] = vreg_s[i] & narrow_s[i] & cnt_nxt[0];
            clear_nxt[i] = vreg_s[i] & (~narrow_s[i] | cnt_nxt[0] | last_nxt);
         end
      end else begin
         valid_nxt = 1'b0;
      end
   end

   // State, counter and latched descriptors.
   always_ff @(posedge clk_i) begin
      if (sync_rst_i) begin
         state_r    <= ST_IDLE;
         cnt_r      <= {CW{1'b0}};
         last_idx_r <= {CW{1'b0}};
         id_r       <= {ID_W{1'b0}};
         vreg_r     <= {N_OPS{1'b0}};
         narrow_r   <= {N_OPS{1'b0}};
         base_r     <= {(5*N_OPS){1'b0}};
      end else begin
         state_r    <= state_nxt;
         cnt_r      <= cnt_nxt;
         last_idx_r <= last_idx_s;
         id_r       <= id_s;
         vreg_r     <= vreg_s;
         narrow_r   <= narrow_s;
         base_r     <= base_s;
      end
   end

   // Registered beat outputs.
   always_ff @(posedge clk_i) begin
      if (sync_rst_i) begin
         beat_valid_o        <= 1'b0;
         beat_id_o           <= {ID_W{1'b0}};
         beat_addr_o         <= {(5*N_OPS){1'b0}};
         beat_fetch_o        <= {N_OPS{1'b0}};
         beat_shift_o        <= {N_OPS{1'b0}};
         beat_clear_hazard_o <= {N_OPS{1'b0}};
         beat_first_o        <= 1'b0;
         beat_last_o         <= 1'b0;
      end else begin
         beat_valid_o        <= valid_nxt;
         beat_id_o           <= id_nxt;
         beat_addr_o         <= addr_nxt;
         beat_fetch_o        <= fetch_nxt;
         beat_shift_o        <= shift_nxt;
         beat_clear_hazard_o <= clear_nxt;
         beat_first_o        <= first_nxt;
         beat_last_o         <= last_nxt;
      end
   end

`ifdef VPROC_OPFETCH_STALL_CNT_EN
   // Count cycles a valid beat is held back by the consumer, saturating.
   always_ff @(posedge clk_i) begin
      if (sync_rst_i) begin
         stall_cnt_o <= 32'd0;
      end else if (beat_valid_o && !beat_ready_i && (stall_cnt_o != 32'hFFFF_FFFF)) begin
         stall_cnt_o <= stall_cnt_o + 32'd1;
      end else begin
         stall_cnt_o <= stall_cnt_o;
      end
   end
`endif

endmodule
